// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the 3-digit seven-segment
//               display controller: digit-slot state encoding, the blank
//               and dash patterns, and the active-low BCD digit table.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Digit slot being scanned: unidades, decenas, centenas.
  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2
  } estado_digito_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_GUION = 7'b0111111;

  // Entry [n] is the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITOS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage : display_pkg
`default_nettype wire

// File: rtl/decodificador_7seg.sv
`default_nettype none
// ============================================================================
// Module      : decodificador_7seg
// Description : Combinational BCD nibble to active-low seven-segment decoder.
//               Nibbles above 9 show a dash; blank forces all segments off.
// Ports       : nibble    in  4  BCD digit
//               blank     in  1  force all segments off
//               segmentos out 7  active-low pattern {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module decodificador_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_GUION;
    if (blank) begin
      segmentos = SEG_BLANK;
    end else if (nibble <= 4'd9) begin
      segmentos = SEG_DIGITOS[nibble];
    end
  end

endmodule : decodificador_7seg
`default_nettype wire

// File: rtl/controlador_display.sv
`default_nettype none
// ============================================================================
// Module      : controlador_display
// Description : Multiplexed 3-digit common-anode seven-segment driver.
//               Captures a packed BCD word on a valid strobe into a shadow
//               register, transfers it to the display register only at the
//               start of a frame (no tearing), applies leading-zero blanking
//               and scans unidades/decenas/centenas with an anode-off guard
//               at the start of every slot.
// Ports       : clk         in  1   system clock
//               rst_n       in  1   asynchronous active-low reset
//               decimal     in  12  BCD {centenas, decenas, unidades}
//               dato_valido in  1   capture strobe for decimal
//               anodos      out 4   active-low digit enables, [3] unused
//               segmentos   out 7   active-low segments {g,f,e,d,c,b,a}
//               punto       out 1   active-low decimal point, held off
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_display
  import display_pkg::*;
#(
  parameter int DIV_REFRESH = 50000,
  parameter int GUARD_CYC   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] decimal,
  input  logic        dato_valido,
  output logic [3:0]  anodos,
  output logic [6:0]  segmentos,
  output logic        punto
);

  localparam int          CW       = $clog2(DIV_REFRESH);
  localparam logic [CW-1:0] c_ultimo = CW'(DIV_REFRESH - 1);
  localparam logic [CW-1:0] c_guarda = CW'(GUARD_CYC);

  estado_digito_t  r_estado;
  logic [CW-1:0]   r_cnt;
  logic [11:0]     r_shadow;
  logic [11:0]     r_display;

  logic [3:0]      w_nibble;
  logic            w_blank;
  logic [3:0]      w_anodo;
  logic [6:0]      w_seg;

  // Digit selection and leading-zero blanking for the slot being scanned.
  // A dash (nibble > 9) is non-zero, so it never triggers blanking.
  always_comb begin
    w_nibble = r_display[3:0];
    w_blank  = 1'b0;
    w_anodo  = 4'b1111;
    case (r_estado)
      DIG0: begin
        w_nibble = r_display[3:0];
        w_anodo  = 4'b1110;
      end
      DIG1: begin
        w_nibble = r_display[7:4];
        w_blank  = (r_display[11:8] == 4'd0) && (r_display[7:4] == 4'd0);
        w_anodo  = 4'b1101;
      end
      DIG2: begin
        w_nibble = r_display[11:8];
        w_blank  = (r_display[11:8] == 4'd0);
        w_anodo  = 4'b1011;
      end
      default: begin
        w_nibble = r_display[3:0];
        w_blank  = 1'b1;
        w_anodo  = 4'b1111;
      end
    endcase
  end

  decodificador_7seg u_decodificador (
    .nibble    (w_nibble),
    .blank     (w_blank),
    .segmentos (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= DIG0;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_display <= '0;
      anodos    <= 4'b1111;
      segmentos <= SEG_BLANK;
    end else begin
      if (dato_valido) begin
        r_shadow <= decimal;
      end

      if (r_cnt == c_ultimo) begin
        r_cnt <= '0;
        case (r_estado)
          DIG0:    r_estado <= DIG1;
          DIG1:    r_estado <= DIG2;
          default: r_estado <= DIG0;
        endcase
        // Frame boundary: the old shadow value is taken, so a strobe on this
        // very edge waits for the following frame.
        if (r_estado == DIG2) begin
          r_display <= r_shadow;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Segments follow the slot even during the guard; anodes stay off.
      anodos    <= (r_cnt < c_guarda) ? 4'b1111 : w_anodo;
      segmentos <= w_seg;
    end
  end

  assign punto = 1'b1;

endmodule : controlador_display
`default_nettype wire

// File: tb/tb_controlador_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_display
// Description : Self-checking bench for controlador_display with a
//               time-based reference model feeding a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_display;

  localparam int DIV   = 4;
  localparam int GUARD = 1;
  localparam int FRAME = 3 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] decimal = 12'h000;
  logic        dato_valido = 1'b0;
  logic [3:0]  anodos;
  logic [6:0]  segmentos;
  logic        punto;

  controlador_display #(
    .DIV_REFRESH (DIV),
    .GUARD_CYC   (GUARD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .decimal     (decimal),
    .dato_valido (dato_valido),
    .anodos      (anodos),
    .segmentos   (segmentos),
    .punto       (punto)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       p;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          mj = 0;          // tick index since reset release
  logic [11:0] m_shadow = 12'h000;
  logic [11:0] m_display = 12'h000;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] patron(input logic [3:0] v);
    logic [6:0] tabla [10];
    tabla = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 4'd9) return 7'b0111111;
    return tabla[v];
  endfunction

  // Expected outputs produced at the end of tick j while showing value val.
  function automatic exp_t modelo(input int j, input logic [11:0] val);
    exp_t e;
    int   slot, pos;
    logic [3:0] nib;
    logic blank;
    slot  = (j / DIV) % 3;
    pos   = j % DIV;
    nib   = val[4*slot +: 4];
    blank = (slot == 2 && val[11:8] == 4'd0) || (slot == 1 && val[11:4] == 8'd0);
    e.an  = (pos < GUARD) ? 4'b1111 : (4'b1111 & ~(4'b0001 << slot));
    e.seg = blank ? 7'b1111111 : patron(nib);
    e.p   = 1'b1;
    return e;
  endfunction

  // Reference model: one expectation per clock edge.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      e.an = 4'b1111; e.seg = 7'b1111111; e.p = 1'b1;
      q.push_back(e);
      mj = 0;
      m_shadow = 12'h000;
      m_display = 12'h000;
    end else begin
      q.push_back(modelo(mj, m_display));
      if (mj % FRAME == FRAME - 1) m_display = m_shadow;
      if (dato_valido) m_shadow = decimal;
      mj++;
    end
  end

  // Monitor: pops and compares, plus anode-0 period measurement.
  int   cyc = 0;
  int   last_act = -1;
  logic prev_a0 = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("anodos", anodos, e.an);
      check("segmentos", segmentos, e.seg);
      check("punto", punto, e.p);
    end
    if (!rst_n) begin
      last_act = -1;
    end else if (prev_a0 && !anodos[0]) begin
      if (last_act >= 0) check("periodo_anodo0", cyc - last_act, FRAME);
      last_act = cyc;
    end
    prev_a0 = anodos[0];
    cyc++;
  end

  task automatic strobe(input logic [11:0] v);
    @(negedge clk);
    decimal = v;
    dato_valido = 1'b1;
    @(negedge clk);
    dato_valido = 1'b0;
  endtask

  task automatic wait_tick(input int t);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (mj % FRAME == t) return;
    end
    check("espera_tick", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME) @(negedge clk);

    strobe(12'h255); repeat (3 * FRAME) @(negedge clk);
    strobe(12'h007); repeat (2 * FRAME) @(negedge clk);
    strobe(12'h100); repeat (2 * FRAME) @(negedge clk);
    strobe(12'h0A3); repeat (2 * FRAME) @(negedge clk);

    // Tearing: second strobe lands on the frame-boundary edge.
    wait_tick(2);
    decimal = 12'h111; dato_valido = 1'b1;
    @(negedge clk); dato_valido = 1'b0;
    wait_tick(FRAME - 1);
    decimal = 12'h222; dato_valido = 1'b1;
    @(negedge clk); dato_valido = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    // Randomised strobes: arbitrary words and BCD with leading zeros.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      dato_valido = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: decimal = 12'($urandom);
          1: decimal = {4'd0, 4'd0, 4'($urandom_range(0, 9))};
          2: decimal = {4'd0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
          default: decimal = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 9))};
        endcase
        dato_valido = 1'b1;
      end
    end
    @(negedge clk);
    dato_valido = 1'b0;
    repeat (FRAME) @(negedge clk);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_anodos", anodos, 4'b1111);
    check("reset_segmentos", segmentos, 7'b1111111);
    check("reset_punto", punto, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FRAME) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_controlador_display
`default_nettype wire

// File: doc/controlador_display.md
Name: controlador_display

Overview:
Multiplexed 3-digit seven-segment driver for the light-sensor reading. It sits directly downstream of the binary-to-BCD converter and consumes its 12-bit packed BCD word {centenas, decenas, unidades}. It captures values on a valid strobe, applies leading-zero blanking, and time-multiplexes the digits onto a 4-anode common-anode display. Anode 3 is unused and held off.

Parameters:
DIV_REFRESH, 50000, clock cycles per digit slot (≥2)
GUARD_CYC, 500, cycles at the start of each slot with all anodes off to prevent ghosting (0 ≤ GUARD_CYC < DIV_REFRESH)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
decimal  input  12  packed BCD: [11:8] centenas, [7:4] decenas, [3:0] unidades
dato_valido  input  1  capture strobe for decimal, one cycle or level
anodos  output  4  active-low digit enables; [0] unidades, [1] decenas, [2] centenas, [3] always 1
segmentos  output  7  active-low segments, order {g,f,e,d,c,b,a}
punto  output  1  active-low decimal point, always 1

Behaviour:
- Clock/reset: single clock clk. Reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n=0.
- Reset values: anodos=4'b1111, segmentos=7'b1111111, punto=1, shadow=0, display register=0, slot counter=0, state=DIG0.
- Capture: if dato_valido=1 on a rising edge, decimal is loaded into the shadow register. The last strobe wins.
- Anti-tearing: the shadow register copies to the display register only on the cycle the FSM enters DIG0, i.e. the counter wraps while in DIG2.
  - A strobe in that same cycle loads the shadow but is not displayed until the next frame.
- FSM states: DIG0 (unidades) -> DIG1 (decenas) -> DIG2 (centenas) -> DIG0.
  - The slot counter counts 0..DIV_REFRESH-1.
  - The state advances when the counter is DIV_REFRESH-1, and the counter wraps to 0.
- Guard: while counter < GUARD_CYC, anodos=4'b1111. Otherwise the active digit's anode is 0 and the others are 1.
- Outputs are registered: they reflect the state/counter one cycle later.
  - Full frame = 3*DIV_REFRESH cycles.
  - Worst-case strobe-to-display latency = 3*DIV_REFRESH + 2 cycles.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble >9 shows dash = 0111111.
- Leading-zero blanking (segmentos=1111111 for the digit):
  - centenas blank when centenas==0.
  - decenas blank when centenas==0 and decenas==0.
  - unidades is never blanked.
  - A dash digit counts as non-zero.
- segmentos during a guard period carries the upcoming digit's pattern. This is harmless because the anodes are off.
- Reset mid-frame forces the reset values immediately. After release, scanning restarts at DIG0 with counter 0 and shows "0" on unidades.

Decomposition:
- Package display_pkg holds:
  - typedef enum estado_digito_t {DIG0, DIG1, DIG2}
  - constants SEG_BLANK=7'b1111111 and SEG_GUION=7'b0111111
  - the 10-entry digit pattern constant array.
- One combinational sub-module, decodificador_7seg: inputs 4-bit nibble and blank, output 7-bit active-low pattern.
- The FSM, counter, shadow/display registers and blanking logic live in controlador_display.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle -> anodos=1111, segmentos=1111111, punto=1 immediately. After release with DIV_REFRESH=4, GUARD_CYC=1 -> unidades shows 1000000 on anodos=1110.
2. Value 12'h255 with strobe, DIV_REFRESH=4, GUARD_CYC=1 -> after the next DIG0 entry the slots show (anodos, segmentos):
   - 1110 with 0010010
   - 1101 with 0010010
   - 1011 with 0100100
   - anodos=1111 on each slot's first output cycle.
3. Blanking with 12'h007 -> centenas and decenas slots show segmentos=1111111, unidades shows 1111000. With 12'h100 -> decenas shows 1000000 (not blanked).
4. Invalid BCD 12'h0A3 -> decenas shows 0111111 and centenas is blanked.
5. Tearing: strobe 12'h111, then strobe 12'h222 in the DIG2→DIG0 transition cycle -> that frame shows all digits 1111001; the following frame shows 0100100.
6. Timing: with DIV_REFRESH=4, count cycles between anode-0 activations -> exactly 12. anodos[3] and punto stay 1 throughout.
